// File: rtl/astar_pkg.sv
// Shared types and saturating arithmetic for the A* search datapath.
package astar_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] MAX_F = 32'hFFFFFFFF;

    typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} exp_state_e;

    // Addition that clamps at a ceiling instead of wrapping.
    function automatic logic [DATA_WIDTH-1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] ceil
    );
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, ceil}) begin
            return ceil;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/manhattan_heuristic.sv
// Manhattan distance between two grid points, zero-extended to DATA_WIDTH.
// Purely combinational; shared with the goal checker.
module manhattan_heuristic #(
    parameter int X_W        = 4,
    parameter int Y_W        = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [X_W-1:0]        a_x_i,
    input  logic [Y_W-1:0]        a_y_i,
    input  logic [X_W-1:0]        b_x_i,
    input  logic [Y_W-1:0]        b_y_i,
    output logic [DATA_WIDTH-1:0] h_o
);

    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    always_comb begin
        dx  = (a_x_i >= b_x_i) ? (a_x_i - b_x_i) : (b_x_i - a_x_i);
        dy  = (a_y_i >= b_y_i) ? (a_y_i - b_y_i) : (b_y_i - a_y_i);
        h_o = DATA_WIDTH'(dx) + DATA_WIDTH'(dy);
    end

endmodule

// File: rtl/astar_node_expander.sv
// Walks the N/E/S/W neighbours of one parent node and enqueues each legal one
// with g+1 and f=g+h; a write holds in EMIT until the queue is ready and not full.
module astar_node_expander
    import astar_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MAP_WIDTH  = 16,
    parameter int                    MAP_HEIGHT = 16,
    parameter logic [DATA_WIDTH-1:0] MAX_F      = 32'hFFFFFFFF,
    parameter int                    X_W        = $clog2(MAP_WIDTH),
    parameter int                    Y_W        = $clog2(MAP_HEIGHT)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [X_W-1:0]        i_node_x,
    input  logic [Y_W-1:0]        i_node_y,
    input  logic [DATA_WIDTH-1:0] i_node_g,
    input  logic [X_W-1:0]        i_goal_x,
    input  logic [Y_W-1:0]        i_goal_y,
    input  logic [3:0]            i_blocked,
    output logic                  o_wrt,
    output logic [DATA_WIDTH-1:0] o_node_f,
    output logic [DATA_WIDTH-1:0] o_node_g,
    output logic [X_W-1:0]        o_node_x,
    output logic [Y_W-1:0]        o_node_y,
    input  logic                  i_ready_enq,
    input  logic                  i_full,
    output logic                  o_done,
    output logic [2:0]            o_count
);

    localparam logic [X_W:0] MAP_W_C = (X_W+1)'(MAP_WIDTH);
    localparam logic [Y_W:0] MAP_H_C = (Y_W+1)'(MAP_HEIGHT);

    exp_state_e            state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [2:0]            count_q, count_d;
    logic [X_W-1:0]        px_q, px_d, gx_q, gx_d;
    logic [Y_W-1:0]        py_q, py_d, gy_q, gy_d;
    logic [DATA_WIDTH-1:0] pg_q, pg_d;
    logic [3:0]            blk_q, blk_d;
    logic [DATA_WIDTH-1:0] nf_q, nf_d, ng_q, ng_d;
    logic [X_W-1:0]        nx_q, nx_d;
    logic [Y_W-1:0]        ny_q, ny_d;

    logic [X_W:0]          cand_x;
    logic [Y_W:0]          cand_y;
    logic                  skip;
    logic [DATA_WIDTH-1:0] h_val, g_n, f_n;

    // Candidate neighbour for the current direction; coordinates carry one
    // extra bit so the east/south bound tests cannot wrap.
    always_comb begin
        cand_x = {1'b0, px_q};
        cand_y = {1'b0, py_q};
        skip   = blk_q[dir_q];
        case (dir_q)
            DIR_N: begin
                cand_y = {1'b0, py_q} - 1'b1;
                skip   = skip | (py_q == '0);
            end
            DIR_E: begin
                cand_x = {1'b0, px_q} + 1'b1;
                skip   = skip | (cand_x >= MAP_W_C);
            end
            DIR_S: begin
                cand_y = {1'b0, py_q} + 1'b1;
                skip   = skip | (cand_y >= MAP_H_C);
            end
            default: begin
                cand_x = {1'b0, px_q} - 1'b1;
                skip   = skip | (px_q == '0);
            end
        endcase
    end

    manhattan_heuristic #(
        .X_W        (X_W),
        .Y_W        (Y_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_heur (
        .a_x_i (cand_x[X_W-1:0]),
        .a_y_i (cand_y[Y_W-1:0]),
        .b_x_i (gx_q),
        .b_y_i (gy_q),
        .h_o   (h_val)
    );

    always_comb begin
        g_n = sat_add(pg_q, DATA_WIDTH'(1), MAX_F);
        f_n = sat_add(g_n, h_val, MAX_F);
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        count_d = count_q;
        px_d    = px_q;
        py_d    = py_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        pg_d    = pg_q;
        blk_d   = blk_q;
        nf_d    = nf_q;
        ng_d    = ng_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    px_d    = i_node_x;
                    py_d    = i_node_y;
                    pg_d    = i_node_g;
                    gx_d    = i_goal_x;
                    gy_d    = i_goal_y;
                    blk_d   = i_blocked;
                    dir_d   = DIR_N;
                    count_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!skip) begin
                    nf_d    = f_n;
                    ng_d    = g_n;
                    nx_d    = cand_x[X_W-1:0];
                    ny_d    = cand_y[Y_W-1:0];
                    state_d = EMIT;
                end else if (dir_q == DIR_W) begin
                    state_d = DONE;
                end else begin
                    dir_d = dir_e'(dir_q + 2'd1);
                end
            end
            EMIT: begin
                if (i_ready_enq && !i_full) begin
                    count_d = count_q + 3'd1;
                    if (dir_q == DIR_W) begin
                        state_d = DONE;
                    end else begin
                        dir_d   = dir_e'(dir_q + 2'd1);
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            dir_q   <= DIR_N;
            count_q <= '0;
            px_q    <= '0;
            py_q    <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            pg_q    <= '0;
            blk_q   <= '0;
            nf_q    <= '1;
            ng_q    <= '1;
            nx_q    <= '0;
            ny_q    <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            px_q    <= px_d;
            py_q    <= py_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            pg_q    <= pg_d;
            blk_q   <= blk_d;
            nf_q    <= nf_d;
            ng_q    <= ng_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
        end
    end

    // All handshake outputs come straight from registers.
    assign o_ready  = (state_q == IDLE);
    assign o_wrt    = (state_q == EMIT);
    assign o_done   = (state_q == DONE);
    assign o_count  = count_q;
    assign o_node_f = nf_q;
    assign o_node_g = ng_q;
    assign o_node_x = nx_q;
    assign o_node_y = ny_q;

endmodule

// File: tb/tb_astar_node_expander.sv
// Directed bench for astar_node_expander with a scoreboard of expected enqueue writes.
module tb_astar_node_expander;

    localparam int MW = 16;
    localparam int MH = 16;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] g;
        logic [31:0] f;
        int          rel;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  i_node_x = '0, i_node_y = '0, i_goal_x = '0, i_goal_y = '0;
    logic [31:0] i_node_g = '0;
    logic [3:0]  i_blocked = '0;
    logic        o_wrt;
    logic [31:0] o_node_f, o_node_g;
    logic [3:0]  o_node_x, o_node_y;
    logic        i_ready_enq = 1'b1;
    logic        i_full = 1'b0;
    logic        o_done;
    logic [2:0]  o_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc = 0;
    exp_t sb[$];

    astar_node_expander dut (
        .CLK(CLK), .RST(RST), .i_valid(i_valid), .o_ready(o_ready),
        .i_node_x(i_node_x), .i_node_y(i_node_y), .i_node_g(i_node_g),
        .i_goal_x(i_goal_x), .i_goal_y(i_goal_y), .i_blocked(i_blocked),
        .o_wrt(o_wrt), .o_node_f(o_node_f), .o_node_g(o_node_g),
        .o_node_x(o_node_x), .o_node_y(o_node_y),
        .i_ready_enq(i_ready_enq), .i_full(i_full),
        .o_done(o_done), .o_count(o_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pushes the expected writes and their cycle offsets.
    task automatic model(input int x, input int y, input logic [31:0] g,
                         input int gx, input int gy, input logic [3:0] m,
                         input int stall, output int done_rel, output int cnt);
        int          t, nx, ny, h, st;
        bit          first, ok;
        logic [31:0] gn;
        logic [32:0] sum;
        exp_t        e;
        t = 1; first = 1; cnt = 0;
        for (int d = 0; d < 4; d++) begin
            nx = x; ny = y;
            case (d)
                0: ny = y - 1;
                1: nx = x + 1;
                2: ny = y + 1;
                default: nx = x - 1;
            endcase
            ok = !m[d] && nx >= 0 && nx < MW && ny >= 0 && ny < MH;
            if (ok) begin
                gn  = (g == 32'hFFFFFFFF) ? g : g + 32'd1;
                h   = ((nx > gx) ? nx - gx : gx - nx) + ((ny > gy) ? ny - gy : gy - ny);
                sum = {1'b0, gn} + 33'(h);
                st  = first ? stall : 0;
                e.x = nx; e.y = ny; e.g = gn;
                e.f = sum[32] ? 32'hFFFFFFFF : sum[31:0];
                e.rel = t + 1 + st;
                sb.push_back(e);
                t += 2 + st;
                first = 0;
                cnt++;
            end else begin
                t += 1;
            end
        end
        done_rel = t;
    endtask

    // Scoreboard side: fields are compared on every o_wrt cycle, so stalls
    // also prove that the outputs hold.
    always @(negedge CLK) begin
        if (!RST && o_wrt) begin
            if (sb.size() == 0) begin
                chk("spurious_wrt", 64'(o_wrt), 64'd0);
            end else begin
                chk("wrt_x", 64'(o_node_x), 64'(sb[0].x));
                chk("wrt_y", 64'(o_node_y), 64'(sb[0].y));
                chk("wrt_g", 64'(o_node_g), 64'(sb[0].g));
                chk("wrt_f", 64'(o_node_f), 64'(sb[0].f));
                if (i_ready_enq && !i_full) begin
                    chk("wrt_cycle", 64'(cyc - acc), 64'(sb[0].rel));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic accept(input int x, input int y, input logic [31:0] g,
                          input int gx, input int gy, input logic [3:0] m);
        int k;
        k = 0;
        @(negedge CLK);
        while (!o_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("ready_wait", 64'(o_ready), 64'd1);
        i_node_x = 4'(x); i_node_y = 4'(y); i_node_g = g;
        i_goal_x = 4'(gx); i_goal_y = 4'(gy); i_blocked = m;
        i_valid = 1'b1;
        @(posedge CLK);
        acc = cyc;
        #1;
        i_valid   = 1'b0;
        i_node_x  = 4'($urandom); i_node_y = 4'($urandom); i_node_g = $urandom;
        i_goal_x  = 4'($urandom); i_goal_y = 4'($urandom); i_blocked = 4'($urandom);
    endtask

    task automatic run(input string tag, input int x, input int y, input logic [31:0] g,
                       input int gx, input int gy, input logic [3:0] m, input int stall);
        int done_rel, cnt, k;
        model(x, y, g, gx, gy, m, stall, done_rel, cnt);
        accept(x, y, g, gx, gy, m);
        @(negedge CLK);
        chk({tag, "_busy"}, 64'(o_ready), 64'd0);
        if (stall > 0) begin
            @(posedge CLK); #1 i_full = 1'b1;
            repeat (stall) @(posedge CLK);
            #1 i_full = 1'b0;
        end
        k = 0;
        while (!o_done && k < 80) begin
            @(negedge CLK);
            k++;
        end
        chk({tag, "_done_seen"}, 64'(o_done), 64'd1);
        chk({tag, "_done_cycle"}, 64'(cyc - acc), 64'(done_rel));
        chk({tag, "_count"}, 64'(o_count), 64'(cnt));
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 64'(o_done), 64'd0);
        chk({tag, "_idle"}, 64'(o_ready), 64'd1);
        sb.delete();
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_wrt", 64'(o_wrt), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_f", 64'(o_node_f), 64'hFFFFFFFF);
        chk("rst_g", 64'(o_node_g), 64'hFFFFFFFF);
        chk("rst_xy", 64'({o_node_x, o_node_y}), 64'd0);

        run("open",   5, 5, 32'd3, 8, 2, 4'b0000, 0);
        run("corner", 0, 0, 32'd0, 15, 15, 4'b0000, 0);
        run("masked", 5, 5, 32'd3, 8, 2, 4'b1111, 0);
        run("far",   15, 15, 32'd7, 0, 0, 4'b0000, 0);
        run("part",   7, 9, 32'd20, 7, 9, 4'b0101, 0);
        run("stall",  5, 5, 32'd3, 8, 2, 4'b0000, 3);
        run("sat",    5, 5, 32'hFFFFFFFE, 15, 15, 4'b0000, 0);
        run("sat1",   8, 8, 32'hFFFFFFFF, 0, 15, 4'b0000, 0);

        // Reset while the first write is pending.
        begin
            int dr, cn;
            model(5, 5, 32'd3, 8, 2, 4'b0000, 0, dr, cn);
            accept(5, 5, 32'd3, 8, 2, 4'b0000);
            @(posedge CLK);
            #1;
            RST = 1'b1;
            i_ready_enq = 1'b0;
            @(posedge CLK);
            #1;
            chk("rst_emit_wrt", 64'(o_wrt), 64'd0);
            chk("rst_emit_ready", 64'(o_ready), 64'd1);
            chk("rst_emit_done", 64'(o_done), 64'd0);
            chk("rst_emit_count", 64'(o_count), 64'd0);
            chk("rst_emit_f", 64'(o_node_f), 64'hFFFFFFFF);
            sb.delete();
            RST = 1'b0;
            i_ready_enq = 1'b1;
        end
        run("after_rst", 5, 5, 32'd3, 8, 2, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
